wbs_ram16: RTL
==============

Name: wbs_ram16

Overview:
- Pipelined Wishbone B4 responder (slave) for the LSU's 16-bit master port.
- Backs a DEPTH-word, 16-bit, byte-lane-writable RAM.
- Requests go into a small in-order queue. Each request is serviced after a programmable number of wait states and returns exactly one ack.
- Stall is asserted when the queue is full. The block serves as bench/integration memory for the decode/exec/lsu/xrs pipeline and as on-chip scratch RAM.

Parameters:
- DEPTH, 1024, RAM size in 16-bit words; power of two, >= 2.
- QDEPTH, 4, request queue entries; power of two, >= 2.
- WAIT_STATES, 0, extra cycles inserted before each request is serviced; 0..15.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  reset, synchronous, active-low: state clears on any rising edge where reset_i==0.
- wbsadr_i  in  64  byte address; word index = wbsadr_i[log2(DEPTH):1]. Bit 0 and higher bits are ignored, so addresses alias.
- wbsdat_i  in  16  write data.
- wbswe_i  in  1  1 = write, 0 = read.
- wbsstb_i  in  1  request strobe.
- wbssel_i  in  2  byte lane select; [0] = bits 7:0, [1] = bits 15:8.
- wbsack_o  out  1  one-cycle acknowledge, one per accepted request.
- wbsstall_o  out  1  queue full; request not accepted.
- wbsdat_o  out  16  read data, valid while wbsack_o==1.

Behaviour:
- Reset (reset_i==0 at an edge):
  - Queue emptied; wait counter = 0.
  - wbsack_o = 0, wbsdat_o = 16'h0000, wbsstall_o = 0.
  - RAM contents preserved.
  - Requests queued before reset are discarded and never acked.
  - A strobe sampled in the same edge as reset is ignored.
- Accept:
  - A request is accepted at an edge where reset_i==1, wbsstb_i==1 and wbsstall_o==0.
  - {adr index, dat, we, sel} is pushed to the queue tail.
  - wbsstall_o is combinational: (count == QDEPTH).
  - A push is never accepted while full, even if a pop occurs in the same cycle.
  - Push and pop in the same edge when not full: count unchanged.
- Service engine (states IDLE, WAIT):
  - IDLE, queue empty: stay IDLE, counter = 0.
  - IDLE, queue non-empty, WAIT_STATES==0: service head this edge.
  - IDLE, queue non-empty, WAIT_STATES>0: go to WAIT, counter = 1.
  - WAIT, counter < WAIT_STATES: counter increments.
  - WAIT, counter == WAIT_STATES: service head; counter = 0; return to IDLE.
- Service at edge E:
  - Pop head. Register wbsack_o = 1 for exactly the cycle after E; it is 0 at every other time.
  - Write: for each sel bit set, update that byte of RAM[index]. wbsdat_o = 0.
  - Read: wbsdat_o = RAM[index] with unselected byte lanes forced to 0. sel==2'b00 returns 16'h0000.
  - Write with sel==2'b00: no RAM change, still acked.
- Latency:
  - With an empty queue, a request accepted at edge N is acked in the cycle following edge N+1+WAIT_STATES, i.e. WAIT_STATES+1 cycles after acceptance.
  - WAIT_STATES==0 sustains one ack per cycle. Otherwise throughput is one ack per WAIT_STATES+1 cycles.
- Ordering:
  - Acks return strictly in acceptance order.
  - A read queued behind a write to the same index returns the written data; there is no hazard window.
- Ack count invariant: number of acks == number of accepted requests, with reset as the only exception.

Test Plan:
- Reset: hold reset_i=0 for 2 edges with wbsstb_i=1 -> wbsack_o=0, wbsstall_o=0, wbsdat_o=0; no ack follows after release.
- W=0, write then read: write adr 0x10 dat 16'hBEEF sel 2'b11, then read adr 0x10 on the next cycle -> ack 1 cycle after each acceptance; second ack carries wbsdat_o=16'hBEEF.
- Byte lanes: write 16'h1234 sel 2'b01 to a word holding 16'hBEEF, then read with sel 2'b11 -> 16'hBE34; read with sel 2'b10 -> 16'hBE00.
- W=3, QDEPTH=4, 8 back-to-back strobes:
  - Stall rises once 4 entries are queued.
  - Acks spaced 4 cycles apart; all 8 acked in order.
  - Stall deasserts the cycle after the first pop.
- Reset mid-operation: 3 reads queued with W=2, pull reset_i low after the first ack -> no further acks; a subsequent read returns the pre-reset RAM value.
- Aliasing: DEPTH=1024, write adr 0x000 then read adr 0x800 -> read data equals the written value.

Source files
------------

// File: rtl/wbs_ram16.sv
// Pipelined Wishbone B4 responder backed by a byte-lane-writable 16-bit RAM.
// Requests are queued in order and each one is serviced after WAIT_STATES cycles.
module wbs_ram16 #(
    parameter int DEPTH       = 1024,
    parameter int QDEPTH      = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] wbsadr_i,
    input  logic [15:0] wbsdat_i,
    input  logic        wbswe_i,
    input  logic        wbsstb_i,
    input  logic [1:0]  wbssel_i,
    output logic        wbsack_o,
    output logic        wbsstall_o,
    output logic [15:0] wbsdat_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int QAW = $clog2(QDEPTH);
    localparam int CW  = QAW + 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [15:0]   dat;
        logic          we;
        logic [1:0]    sel;
    } req_t;

    state_t         state, state_nxt;
    logic [3:0]     wait_cnt, cnt_nxt;
    logic [QAW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push, service;
    req_t           head;
    logic [15:0]    lane_mask;
    logic [15:0]    rd_word;

    // NOTE: RAM and queue payload have no reset; only the control state that
    // decides validity is cleared, so stale contents are never observed.
    logic [15:0] mem   [DEPTH];
    req_t        queue [QDEPTH];

    // Address bit 0 and everything above the word index alias by design.
    logic unused_adr;
    assign unused_adr = ^{wbsadr_i[63:AW+1], wbsadr_i[0]};

    assign wbsstall_o = (count == CW'(QDEPTH));
    assign push       = reset_i && wbsstb_i && !wbsstall_o;
    assign head       = queue[rd_ptr];
    assign lane_mask  = {{8{head.sel[1]}}, {8{head.sel[0]}}};
    assign rd_word    = mem[head.idx] & lane_mask;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        service   = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    if (WS == 4'd0) begin
                        service = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 4'd1;
                    end
                end else begin
                    cnt_nxt = 4'd0;
                end
            end
            S_WAIT: begin
                if (wait_cnt == WS) begin
                    service   = 1'b1;
                    cnt_nxt   = 4'd0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = wait_cnt + 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wbsack_o <= 1'b0;
            wbsdat_o <= 16'h0000;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (service) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(push) - CW'(service);
            wbsack_o <= service;
            wbsdat_o <= (service && !head.we) ? rd_word : 16'h0000;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            queue[wr_ptr] <= '{idx: wbsadr_i[AW:1], dat: wbsdat_i,
                               we: wbswe_i, sel: wbssel_i};
        end
    end

    // A write serviced in a reset edge belongs to a discarded request.
    always_ff @(posedge clk_i) begin
        if (reset_i && service && head.we) begin
            if (head.sel[0]) mem[head.idx][7:0]  <= head.dat[7:0];
            if (head.sel[1]) mem[head.idx][15:8] <= head.dat[15:8];
        end
    end

endmodule
